// File: rtl/tx_buffer_ctrl.sv
// tx_buffer_ctrl: ping-pong transmit buffer. The DSP fills and commits banks,
// each slot streams one committed bank byte-wise, and a refill interrupt follows.
module tx_buffer_ctrl #(
  parameter int BANK_WORDS = 128,
  parameter int INT_CYCLES = 400
) (
  input  logic        logic_clk_in,
  input  logic        logic_rst_in,
  input  logic        ram_wr_in,
  input  logic [7:0]  addr_wr_in,
  input  logic [31:0] ram_data_in,
  input  logic        commit_in,
  input  logic        commit_bank_in,
  input  logic        tx_slot_interrupt,
  input  logic [8:0]  tx_slot_length,
  output logic [7:0]  data_out,
  output logic        data_valid_out,
  input  logic        data_ready_in,
  output logic        tx_done_out,
  output logic        tx_dsp_interrupt_out,
  output logic        underrun_out,
  output logic        err_out,
  output logic [63:0] debug_signal
);
  localparam int CW = $clog2(INT_CYCLES);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  state_t        state_q, state_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic          rd_bank_q, rd_bank_d;
  logic [8:0]    byte_cnt_q, byte_cnt_d;
  logic [8:0]    len_q, len_d;
  logic          int_on_q, int_on_d;
  logic [CW-1:0] int_cnt_q, int_cnt_d;
  logic          underrun_q, underrun_d;
  logic          err_q, err_d;
  logic [31:0]   ram [2*BANK_WORDS];
  logic [31:0]   rd_word_q;
  logic          wr_ok, commit_ok;
  logic [1:0]    lane;
  // A bank that is full is also the only one that can be mid-transfer, but the
  // explicit busy test keeps the rule obvious.
  assign wr_ok     = ram_wr_in && !bank_full_q[addr_wr_in[7]] &&
                     !(state_q != IDLE && addr_wr_in[7] == rd_bank_q);
  assign commit_ok = commit_in && !bank_full_q[commit_bank_in];
  assign lane      = byte_cnt_q[1:0];
  always_ff @(posedge logic_clk_in) begin
    if (wr_ok) ram[addr_wr_in] <= ram_data_in;
    if (state_q == LOAD) rd_word_q <= ram[{rd_bank_q, byte_cnt_q[8:2]}];
  end
  always_comb begin
    state_d     = state_q;
    bank_full_d = bank_full_q;
    rd_bank_d   = rd_bank_q;
    byte_cnt_d  = byte_cnt_q;
    len_d       = len_q;
    underrun_d  = 1'b0;
    err_d       = (ram_wr_in && !wr_ok) || (commit_in && !commit_ok) ||
                  (tx_slot_interrupt && state_q != IDLE);
    int_on_d    = int_on_q && int_cnt_q != CW'(INT_CYCLES - 1);
    int_cnt_d   = int_on_d ? int_cnt_q + 1'b1 : '0;
    if (commit_ok) bank_full_d[commit_bank_in] = 1'b1;
    case (state_q)
      IDLE: if (tx_slot_interrupt) begin
        if (bank_full_q[rd_bank_q]) begin
          len_d      = tx_slot_length;
          byte_cnt_d = '0;
          state_d    = tx_slot_length == '0 ? DONE : LOAD;
        end else underrun_d = 1'b1;
      end
      LOAD: state_d = SEND;
      SEND: if (data_ready_in) begin
        byte_cnt_d = byte_cnt_q + 1'b1;
        state_d    = (byte_cnt_q + 9'd1 == len_q) ? DONE : (lane == 2'd3 ? LOAD : SEND);
      end
      default: begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = !rd_bank_q;
        int_on_d               = 1'b1;
        int_cnt_d              = '0;
        state_d                = IDLE;
      end
    endcase
  end
  always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
    if (logic_rst_in) begin
      state_q     <= IDLE;
      bank_full_q <= '0;
      rd_bank_q   <= 1'b0;
      byte_cnt_q  <= '0;
      len_q       <= '0;
      int_on_q    <= 1'b0;
      int_cnt_q   <= '0;
      underrun_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_full_q <= bank_full_d;
      rd_bank_q   <= rd_bank_d;
      byte_cnt_q  <= byte_cnt_d;
      len_q       <= len_d;
      int_on_q    <= int_on_d;
      int_cnt_q   <= int_cnt_d;
      underrun_q  <= underrun_d;
      err_q       <= err_d;
    end
  end
  assign data_valid_out       = state_q == SEND;
  assign data_out             = data_valid_out ? rd_word_q[{lane, 3'b000} +: 8] : 8'h00;
  assign tx_done_out          = state_q == DONE;
  assign tx_dsp_interrupt_out = int_on_q;
  assign underrun_out         = underrun_q;
  assign err_out              = err_q;
  assign debug_signal         = {48'h0, data_ready_in, data_valid_out, byte_cnt_q, state_q,
                                 rd_bank_q, bank_full_q};
endmodule

// File: tb/tb_tx_buffer_ctrl.sv
// tb_tx_buffer_ctrl: randomized scoreboard bench; a byte-array bank model
// predicts every streamed byte and the done/err/underrun pulse counts.
module tb_tx_buffer_ctrl;
  logic        clk = 0, rst = 1;
  logic        ram_wr_in = 0, commit_in = 0, commit_bank_in = 0, tx_slot_interrupt = 0;
  logic [7:0]  addr_wr_in = 0;
  logic [31:0] ram_data_in = 0;
  logic [8:0]  tx_slot_length = 0;
  logic        data_ready_in = 1;
  logic [7:0]  data_out;
  logic        data_valid_out, tx_done_out, tx_dsp_interrupt_out, underrun_out, err_out;
  logic [63:0] debug_signal;

  tx_buffer_ctrl dut (
    .logic_clk_in(clk), .logic_rst_in(rst), .ram_wr_in(ram_wr_in), .addr_wr_in(addr_wr_in),
    .ram_data_in(ram_data_in), .commit_in(commit_in), .commit_bank_in(commit_bank_in),
    .tx_slot_interrupt(tx_slot_interrupt), .tx_slot_length(tx_slot_length),
    .data_out(data_out), .data_valid_out(data_valid_out), .data_ready_in(data_ready_in),
    .tx_done_out(tx_done_out), .tx_dsp_interrupt_out(tx_dsp_interrupt_out),
    .underrun_out(underrun_out), .err_out(err_out), .debug_signal(debug_signal));

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;
  int cnt_done = 0, cnt_err = 0, cnt_und = 0;
  int exp_done = 0, exp_err = 0, exp_und = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_mem [2][512];
  logic       m_full [2];
  logic       m_rd = 0, busy = 0, busy_b = 0, rand_rdy = 0;
  logic       prev_stall = 0;
  logic [7:0] prev_data = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1 data_ready_in = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: pops the scoreboard on every accepted byte and tallies pulses.
  always @(negedge clk) begin
    if (tx_done_out) begin
      cnt_done++;
      chk("bytes_left_at_done", exp_q.size(), 0);
    end
    if (underrun_out) cnt_und++;
    if (err_out) cnt_err++;
    if (prev_stall) chk("hold_stable", {data_valid_out, data_out}, {1'b1, prev_data});
    if (data_valid_out && data_ready_in) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_byte: got %0h expected no byte", data_out);
      end else chk("byte", data_out, exp_q.pop_front());
    end
    prev_stall = data_valid_out && !data_ready_in;
    prev_data  = data_out;
  end

  function automatic logic [31:0] pat(input int w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'(4 * w + k);
    return r;
  endfunction

  task automatic wr(input logic b, input int w, input logic [31:0] d, input logic cm);
    ram_wr_in = 1; addr_wr_in = {b, 7'(w)}; ram_data_in = d;
    commit_in = cm; commit_bank_in = b;
    if (!m_full[b] && !(busy && busy_b == b))
      for (int k = 0; k < 4; k++) m_mem[b][4 * w + k] = d[8*k +: 8];
    else exp_err++;
    if (cm) begin
      if (m_full[b]) exp_err++;
      else m_full[b] = 1;
    end
    tick();
    ram_wr_in = 0; commit_in = 0;
  endtask

  task automatic commit(input logic b);
    commit_in = 1; commit_bank_in = b;
    if (m_full[b]) exp_err++;
    else m_full[b] = 1;
    tick();
    commit_in = 0;
  endtask

  task automatic fill(input logic b, input int n, input logic rnd);
    for (int w = 0; w < n; w++) wr(b, w, rnd ? $urandom : pat(w), 0);
  endtask

  task automatic slot(input logic [8:0] len);
    logic go;
    go = !busy && m_full[m_rd];
    tx_slot_interrupt = 1; tx_slot_length = len;
    if (busy) exp_err++;
    else if (!go) exp_und++;
    else begin
      for (int i = 0; i < int'(len); i++) exp_q.push_back(m_mem[m_rd][i]);
      exp_done++; busy = 1; busy_b = m_rd; m_full[m_rd] = 0; m_rd = !m_rd;
    end
    tick();
    tx_slot_interrupt = 0;
    if (go) begin
      @(negedge clk);
      if (len == 0) chk("done_immediate", tx_done_out, 1);
      else begin
        chk("lat_first_cycle", data_valid_out, 0);
        @(negedge clk);
        chk("lat_second_cycle", data_valid_out, 1);
      end
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000 && cnt_done < exp_done; i++) tick();
    chk("done_seen", cnt_done, exp_done);
    busy = 0;
  endtask

  task automatic check_counts();
    repeat (3) tick();
    chk("done_count", cnt_done, exp_done);
    chk("err_count", cnt_err, exp_err);
    chk("underrun_count", cnt_und, exp_und);
  endtask

  initial begin
    m_full[0] = 0; m_full[1] = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid_out, 0);
    chk("rst_done", tx_done_out, 0);
    chk("rst_int", tx_dsp_interrupt_out, 0);
    chk("rst_flags", {underrun_out, err_out}, 0);
    tick();
    rst = 0;
    tick();
    // Nothing committed yet.
    slot(10);
    check_counts();
    // Incrementing bytes, no backpressure, then measure the refill interrupt.
    fill(0, 32, 0);
    commit(0);
    slot(128);
    wait_done();
    begin
      int n = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (tx_dsp_interrupt_out) n++;
        else if (n > 0) break;
      end
      chk("int_high_cycles", n, 400);
    end
    check_counts();
    // Same data from bank1 under random backpressure.
    fill(1, 32, 0);
    commit(1);
    rand_rdy = 1;
    slot(128);
    wait_done();
    check_counts();
    // Distinct banks, write+commit in one cycle, duplicate commit, third slot underruns.
    fill(0, 128, 1);
    commit(0);
    fill(1, 127, 1);
    wr(1, 127, $urandom, 1);
    commit(0);
    slot(9'($urandom_range(1, 511)));
    wait_done();
    slot(511);
    wait_done();
    slot(9);
    check_counts();
    // Writes and a slot interrupt while bank0 is streaming.
    fill(0, 16, 1);
    commit(0);
    slot(64);
    wr(0, 3, 32'hDEADBEEF, 0);
    slot(10);
    wr(1, 0, 32'h12345678, 0);
    wait_done();
    check_counts();
    // Length 5 across a word boundary, then length 0.
    fill(1, 4, 1);
    commit(1);
    slot(5);
    wait_done();
    commit(0);
    slot(0);
    wait_done();
    slot(4);
    check_counts();
    // Random traffic.
    for (int it = 0; it < 4; it++) begin
      for (int b = 0; b < 2; b++)
        if (!m_full[b]) begin
          fill(1'(b), 128, 1);
          commit(1'(b));
        end
      if ($urandom_range(0, 1) == 1) commit(1'($urandom_range(0, 1)));
      slot(9'($urandom_range(0, 511)));
      wait_done();
      slot(9'($urandom_range(0, 511)));
      wait_done();
    end
    check_counts();
    // Asynchronous reset in the middle of SEND.
    rand_rdy = 0;
    repeat (2) tick();
    fill(m_rd, 64, 1);
    commit(m_rd);
    slot(200);
    repeat (20) tick();
    for (int i = 0; i < 10 && !data_valid_out; i++) tick();
    chk("pre_rst_valid", data_valid_out, 1);
    #1 rst = 1;
    #1 chk("rst_mid_valid", data_valid_out, 0);
    exp_q.delete(); exp_done--;
    m_full[0] = 0; m_full[1] = 0; m_rd = 0; busy = 0;
    repeat (2) tick();
    rst = 0;
    tick();
    slot(3);
    check_counts();
    fill(0, 2, 1);
    commit(0);
    slot(7);
    wait_done();
    check_counts();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end
endmodule
